icache_responder: RTL

- Cache-side responder for the datapath's instruction-fetch channel.
- Accepts imemREN/imemaddr from the pipelined datapath and returns ihit/imemload.
- Direct-mapped, one-word-block instruction cache. Misses are refilled from the memory controller over an iREN/iaddr/iwait/iload request channel.
- Sits between the datapath and the memory arbiter, inside the caches wrapper.

---
 rtl/icache_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache responder with a blocking refill FSM.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache_responder #(
  parameter int unsigned NFRAMES  = 16,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                imemREN,
  input  logic [PC_WIDTH-1:0] imemaddr,
  output logic                ihit,
  output logic [PC_WIDTH-1:0] imemload,
  input  logic                flush,
  output logic                iREN,
  output logic [PC_WIDTH-1:0] iaddr,
  input  logic                iwait,
  input  logic [PC_WIDTH-1:0] iload,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int unsigned IDX_W = $clog2(NFRAMES);
  localparam int unsigned TAG_W = PC_WIDTH - IDX_W - 2;

  typedef enum logic {StIdle, StFetch} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [NFRAMES-1:0]  r_valid;
  logic [TAG_W-1:0]    r_tag  [NFRAMES];
  logic [PC_WIDTH-1:0] r_data [NFRAMES];
  logic [PC_WIDTH-1:0] r_fetch_addr;
  logic                r_drop;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_fidx;
  logic [TAG_W-1:0]    w_ftag;
  logic                w_hit;
  logic                w_start;
  logic                w_install;
  logic                w_unused;

  assign w_idx    = imemaddr[IDX_W+1:2];
  assign w_tag    = imemaddr[PC_WIDTH-1:IDX_W+2];
  assign w_fidx   = r_fetch_addr[IDX_W+1:2];
  assign w_ftag   = r_fetch_addr[PC_WIDTH-1:IDX_W+2];
  assign w_hit    = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_unused = ^{imemaddr[1:0], r_fetch_addr[1:0]};

  always_comb begin
    w_state_next = r_state;
    ihit         = 1'b0;
    imemload     = '0;
    iREN         = 1'b0;
    iaddr        = '0;
    w_start      = 1'b0;
    w_install    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_hit && !flush && !RST) begin
          ihit     = 1'b1;
          imemload = r_data[w_idx];
        end else if (imemREN && !w_hit) begin
          w_start      = 1'b1;
          w_state_next = StFetch;
        end
      end
      StFetch: begin
        iREN  = 1'b1;
        iaddr = r_fetch_addr;
        if (!iwait) begin
          w_state_next = StIdle;
          // A flush seen at any point of the refill makes the returned word stale.
          w_install    = !r_drop && !flush && !RST;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= StIdle;
      r_valid      <= '0;
      r_fetch_addr <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_fetch_addr <= {imemaddr[PC_WIDTH-1:2], 2'b00};
        r_drop       <= 1'b0;
      end else if (flush && r_state == StFetch) begin
        r_drop <= 1'b1;
      end
      if (flush) begin
        r_valid <= '0;
      end else if (w_install) begin
        r_valid[w_fidx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_install) begin
      r_tag[w_fidx]  <= w_ftag;
      r_data[w_fidx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (r_state == StIdle && w_hit && r_hit_count != 32'hFFFF_FFFF) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_start && r_miss_count != 32'hFFFF_FFFF) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
